bcd_to_bin_seq: RTL and testbench
=================================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3.
//  Inverse of the binary-to-BCD path. Takes packed BCD from keypad/display logic and returns
//  an unsigned binary value for the arithmetic datapath.
//  Processes one bit per clock and uses a start/done handshake.
// PARAMETERS
//  N_DIGITS  4   number of packed BCD digits at the input
//  BIN_W     14  binary result width; must satisfy 2**BIN_W > 10**N_DIGITS - 1
// PORTS
//  clk       in   1           system clock, rising edge
//  reset_n   in   1           synchronous reset, active-low
//  start     in   1           request a conversion; accepted only while ready=1
//  bcd_in    in   4*N_DIGITS  packed BCD, digit 0 in [3:0]; sampled on the accepting edge
//  ready     out  1           block is in IDLE and can accept start
//  done      out  1           one-cycle pulse: bin_out and error are valid
//  bin_out   out  BIN_W       converted value; held from done until the next accepted start
//  error     out  1           an input digit was >9; held with bin_out
// BEHAVIOUR
//  - Reset (reset_n=0 at a clk edge): state=IDLE, ready=1, done=0, bin_out=0, error=0,
//    shift register and counter cleared. Reset mid-conversion aborts it; no done pulse follows.
//  - States:
//    IDLE -> CONV when start=1, all digits are <=9.
//    IDLE -> FIN when start=1 and any digit is >9.
//    CONV -> FIN after exactly BIN_W shift cycles.
//    FIN -> IDLE unconditionally.
//  - Accept edge k:
//    latch bcd_in into bcd_sr.
//    clear bin_sr and cnt.
//    clear error and bin_out.
//    drop ready.
//  - CONV, each cycle:
//    {bcd_sr,bin_sr} shifts right 1, so bcd_sr[0] enters bin_sr[MSB].
//    Each shifted digit d becomes (d>=8) ? d-3 : d.
//    cnt increments. Leave CONV when cnt==BIN_W-1.
//  - FIN:
//    done=1 for exactly one cycle.
//    bin_out<=bin_sr, error as detected.
//    ready returns to 1 the following cycle.
//  - Latency: valid conversion has done high in cycle k+BIN_W+1; invalid input has done in cycle k+1.
//    The invalid-input path gives error=1 and bin_out=0.
//  - start while ready=0 is ignored (no queueing). bcd_in changes after acceptance have no effect.
//  - start asserted in the same cycle done pulses is ignored. It is accepted in the next IDLE cycle.
//  - All arithmetic is unsigned. A digit after correction is always <=9 when the input is valid.
//    When bcd_sr reaches zero early, the remaining shifts only move bin_sr; no special-casing.
//  - bin_out/error change only in FIN, on accept (cleared), or on reset.
// STRUCTURE
//  - Package bcd_pkg holds:
//    BCD_DIGIT_W=4
//    typedef logic [3:0] bcd_digit_t
//    typedef enum logic [1:0] {IDLE, CONV, FIN} b2b_state_t
//    function is_valid_bcd(bcd_digit_t) returning d<=9
//  - One sub-module, bcd_sub3:
//    4-bit in, 4-bit out; out = (in>=8) ? in-3 : in.
//    Instantiated N_DIGITS times via generate on the shifted bcd_sr digits.
//  - Top holds:
//    FSM
//    counter, width $clog2(BIN_W)
//    shift registers
//    output registers
// TESTING
//  - Reset then idle:
//    ready=1, done=0, bin_out=0, error=0.
//    start with reset_n=0 has no effect.
//  - bcd_in=16'h1234, start at k: done only at k+15, bin_out=14'h04D2, error=0.
//  - bcd_in=16'h9999 gives bin_out=14'h270F.
//    bcd_in=16'h0000 gives bin_out=0, done at k+15.
//  - bcd_in=16'h12A4: done at k+1, error=1, bin_out=0.
//    A following 16'h0042 gives error=0 and bin_out=14'h002A.
//  - Start 16'h0500, then pulse start with 16'h0007 at k+3:
//    the second start is ignored, bin_out=14'h01F4 at k+15.
//  - reset_n=0 at k+6 of a conversion:
//    no done pulse, outputs are 0 and ready=1 after reset.
//    A new 16'h0001 returns bin_out=1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, CONV, FIN} b2b_state_t;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble digit correction: subtract 3 from any digit >= 8.
module bcd_sub3
  import bcd_pkg::*;
(
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd8) ? (in - 4'd3) : in;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock, start/done handshake.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [N_DIGITS*BCD_DIGIT_W-1:0] bcd_in,
  output logic                            ready,
  output logic                            done,
  output logic [BIN_W-1:0]                bin_out,
  output logic                            error
);

  localparam int unsigned BCD_W = N_DIGITS * BCD_DIGIT_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  b2b_state_t        state_q, state_d;
  logic [BCD_W-1:0]  bcd_sr_q, bcd_sr_d;
  logic [BIN_W-1:0]  bin_sr_q, bin_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              error_q, error_d;

  logic [BCD_W-1:0]  bcd_shift;
  logic [BCD_W-1:0]  bcd_corr;
  logic [BIN_W-1:0]  bin_shift;
  logic              in_valid;

  assign bcd_shift = bcd_sr_q >> 1;
  assign bin_shift = {bcd_sr_q[0], bin_sr_q[BIN_W-1:1]};

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_sub3
    bcd_sub3 u_sub3 (
      .in  (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .out (bcd_corr [g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    in_valid = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!is_valid_bcd(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = in_valid ? CONV : FIN;
      CONV:    if (cnt_q == CNT_LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == FIN);
  end

  // bin_out is loaded on the final shift edge so it is already valid while done is high.
  always_comb begin
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    error_d   = error_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_sr_d  = bcd_in;
          bin_sr_d  = '0;
          cnt_d     = '0;
          bin_out_d = '0;
          error_d   = !in_valid;
        end
      end
      CONV: begin
        bcd_sr_d = bcd_corr;
        bin_sr_d = bin_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) bin_out_d = bin_shift;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      error_q   <= 1'b0;
    end else begin
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      error_q   <= error_d;
    end
  end

  assign bin_out = bin_out_q;
  assign error   = error_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (N_DIGITS=4, BIN_W=14).
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        ready;
  logic        done;
  logic [13:0] bin_out;
  logic        error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.N_DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .done    (done),
    .bin_out (bin_out),
    .error   (error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; returns in cycle k+1 (just after the accept edge).
  task automatic do_accept(input logic [15:0] v);
    start  = 1'b1;
    bcd_in = v;
    step();
    start  = 1'b0;
  endtask

  // Returns cycle offset from k at which done is first seen, or -1 if never.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    bcd_in  = 16'h1234;
    repeat (3) step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bin_out !== 14'h0) begin failures++; $display("FAIL reset_bin got=%h exp=0", bin_out); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (2) step();
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset got ready=%b done=%b exp ready=1 done=0", ready, done); end
  endtask

  task automatic test_basic();
    int lat;
    do_accept(16'h1234);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_drop got=%b exp=0", ready); end
    wait_done(lat);
    checks++; if (lat != 15) begin failures++; $display("FAIL basic_latency got=%0d exp=15", lat); end
    checks++; if (bin_out !== 14'h04D2 || error !== 1'b0) begin failures++; $display("FAIL basic_1234 got bin=%h err=%b exp bin=04d2 err=0", bin_out, error); end
    step();
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL basic_done_pulse got done=%b ready=%b exp done=0 ready=1", done, ready); end
    checks++; if (bin_out !== 14'h04D2) begin failures++; $display("FAIL basic_hold got=%h exp=04d2", bin_out); end
  endtask

  task automatic test_extremes();
    int lat;
    do_accept(16'h9999);
    wait_done(lat);
    checks++; if (lat != 15 || bin_out !== 14'h270F) begin failures++; $display("FAIL max_9999 got lat=%0d bin=%h exp lat=15 bin=270f", lat, bin_out); end
    step();
    do_accept(16'h0000);
    wait_done(lat);
    checks++; if (lat != 15 || bin_out !== 14'h0 || error !== 1'b0) begin failures++; $display("FAIL zero got lat=%0d bin=%h err=%b exp lat=15 bin=0 err=0", lat, bin_out, error); end
    step();
  endtask

  task automatic test_invalid();
    int lat;
    do_accept(16'h12A4);
    wait_done(lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL invalid_latency got=%0d exp=1", lat); end
    checks++; if (error !== 1'b1 || bin_out !== 14'h0) begin failures++; $display("FAIL invalid_out got err=%b bin=%h exp err=1 bin=0", error, bin_out); end
    step();
    checks++; if (ready !== 1'b1 || error !== 1'b1) begin failures++; $display("FAIL invalid_hold got ready=%b err=%b exp ready=1 err=1", ready, error); end
    do_accept(16'h0042);
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL accept_clears_error got=%b exp=0", error); end
    wait_done(lat);
    checks++; if (lat != 15 || bin_out !== 14'h002A || error !== 1'b0) begin failures++; $display("FAIL after_invalid got lat=%0d bin=%h err=%b exp lat=15 bin=002a err=0", lat, bin_out, error); end
    step();
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    do_accept(16'h0500);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (i == 3) begin
        start  = 1'b1;
        bcd_in = 16'h0007;
      end else begin
        start  = 1'b0;
      end
      step();
    end
    checks++; if (lat != 15 || bin_out !== 14'h01F4) begin failures++; $display("FAIL ignore_start got lat=%0d bin=%h exp lat=15 bin=01f4", lat, bin_out); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    checks++; if (extra != 0 || ready !== 1'b1) begin failures++; $display("FAIL no_queued_start got dones=%0d ready=%b exp dones=0 ready=1", extra, ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_accept(16'h1234);
    wait_done(lat);
    checks++; if (lat != 15) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=15", lat); end
    start  = 1'b1;
    bcd_in = 16'h0099;
    step();
    checks++; if (ready !== 1'b1 || bin_out !== 14'h04D2) begin failures++; $display("FAIL start_in_fin_ignored got ready=%b bin=%h exp ready=1 bin=04d2", ready, bin_out); end
    step();
    start = 1'b0;
    checks++; if (ready !== 1'b0 || bin_out !== 14'h0) begin failures++; $display("FAIL b2b_accept got ready=%b bin=%h exp ready=0 bin=0", ready, bin_out); end
    wait_done(lat);
    checks++; if (lat != 15 || bin_out !== 14'h0063) begin failures++; $display("FAIL b2b_second got lat=%0d bin=%h exp lat=15 bin=0063", lat, bin_out); end
    step();
  endtask

  task automatic test_reset_abort();
    int lat;
    int extra;
    do_accept(16'h1234);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    checks++; if (ready !== 1'b1 || done !== 1'b0 || bin_out !== 14'h0 || error !== 1'b0) begin failures++; $display("FAIL abort_reset got ready=%b done=%b bin=%h err=%b exp 1 0 0 0", ready, done, bin_out, error); end
    reset_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) extra++;
      step();
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL abort_no_done got dones=%0d exp=0", extra); end
    do_accept(16'h0001);
    wait_done(lat);
    checks++; if (lat != 15 || bin_out !== 14'h0001) begin failures++; $display("FAIL after_abort got lat=%0d bin=%h exp lat=15 bin=0001", lat, bin_out); end
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bcd_in  = '0;
    step();
    test_reset();
    test_basic();
    test_extremes();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
